// File: rtl/gru_seq_ctrl.sv
// gru_seq_ctrl
// Sequence controller wrapped around a combinational GRU cell. It holds the
// recurrent hidden state and accepts one input sample per time step through a
// valid/ready handshake. It presents X and h to the cell and holds them for
// CELL_LAT cycles, then captures h_out back into the hidden state. Every
// captured step is streamed on h_step. The last step of a sequence is also
// latched into h_final. Data words are opaque here, so FRACT_WIDTH only
// documents the fixed-point format.

module gru_seq_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRACT_WIDTH = 5,
    parameter int SEQ_LEN     = 16,
    parameter int CNT_W       = 8,
    parameter int CELL_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] h_init,
    input  logic [DATA_WIDTH-1:0] x_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    output logic [DATA_WIDTH-1:0] cell_x,
    output logic [DATA_WIDTH-1:0] cell_h,
    input  logic [DATA_WIDTH-1:0] cell_h_out,
    output logic [DATA_WIDTH-1:0] h_step,
    output logic                  h_step_valid,
    output logic [CNT_W-1:0]      step_idx,
    output logic [DATA_WIDTH-1:0] h_final,
    output logic                  done,
    output logic                  busy
);

    // The settle counter only has to reach CELL_LAT-1.
    localparam int SW = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(CELL_LAT - 1);
    localparam logic [CNT_W-1:0] LAST_STEP   = CNT_W'(SEQ_LEN - 1);

    // The settle count must be at least one cycle, and the step counter must
    // never need to wrap. The fixed-point split must leave at least one
    // integer bit.
    localparam bit PARAMS_OK = (CELL_LAT >= 1) && (SEQ_LEN >= 1) &&
                               (SEQ_LEN <= (2 ** CNT_W) - 1) &&
                               (FRACT_WIDTH < DATA_WIDTH);

    // An illegal parameter set elaborates this empty marker scope. A checker
    // module can bind to that scope to flag the configuration.
    if (!PARAMS_OK) begin : g_illegal_params
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_X = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] h_reg;
    logic [DATA_WIDTH-1:0] x_reg;
    logic [CNT_W-1:0]      step;
    logic [SW-1:0]         settle;

    // The cell inputs come straight from the held registers, so they stay
    // stable for the whole settle window.
    assign cell_x  = x_reg;
    assign cell_h  = h_reg;
    assign x_ready = (state == WAIT_X);

    // Sequencer FSM: handshake, settle, capture and end-of-sequence
    // reporting, with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            h_reg        <= '0;
            x_reg        <= '0;
            step         <= '0;
            settle       <= '0;
            h_step       <= '0;
            h_step_valid <= 1'b0;
            step_idx     <= '0;
            h_final      <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Both status outputs are single-cycle pulses.
            h_step_valid <= 1'b0;
            done         <= 1'b0;
            if (abort) begin
                // Abort drops all progress. h_final keeps the last full
                // result. Aborting while already idle changes nothing.
                if (state != IDLE) begin
                    state <= IDLE;
                    step  <= '0;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            h_reg <= h_init;
                            step  <= '0;
                            busy  <= 1'b1;
                            state <= WAIT_X;
                        end
                    end
                    WAIT_X: begin
                        if (x_valid) begin
                            x_reg  <= x_data;
                            settle <= '0;
                            state  <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        settle <= settle + SW'(1);
                        if (settle == SETTLE_LAST) begin
                            h_reg        <= cell_h_out;
                            h_step       <= cell_h_out;
                            step_idx     <= step;
                            h_step_valid <= 1'b1;
                            if (step == LAST_STEP) begin
                                h_final <= cell_h_out;
                                state   <= DONE;
                            end else begin
                                step  <= step + CNT_W'(1);
                                state <= WAIT_X;
                            end
                        end
                    end
                    DONE: begin
                        // done follows the final h_step_valid by one cycle.
                        // busy falls at the same moment.
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Self-checking bench for gru_seq_ctrl. It builds three instances:
// (a) CELL_LAT=1, SEQ_LEN=4; (b) CELL_LAT=3, SEQ_LEN=4; (c) CELL_LAT=1, SEQ_LEN=1.
// All three share the same stimulus, but only the selected instance is
// compared each cycle against a timestamp-based reference model.

module tb_gru_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, x_valid;
    logic [7:0] h_init, x_data;
    logic       glitch;
    logic [7:0] junk;
    int         cur;

    // Clock generation.
    always #5 clk = ~clk;

    logic       xr_a, hsv_a, dn_a, bz_a;
    logic [7:0] cx_a, ch_a, cho_a, hs_a, idx_a, hf_a;
    logic       xr_b, hsv_b, dn_b, bz_b;
    logic [7:0] cx_b, ch_b, cho_b, hs_b, idx_b, hf_b;
    logic       xr_c, hsv_c, dn_c, bz_c;
    logic [7:0] cx_c, ch_c, cho_c, hs_c, idx_c, hf_c;

    // The stub cell computes h_out = x + h. It adds junk on every settle
    // cycle except the last, so an early capture picks up the wrong value.
    assign cho_a = glitch ? (cx_a + ch_a + junk) : (cx_a + ch_a);
    assign cho_b = glitch ? (cx_b + ch_b + junk) : (cx_b + ch_b);
    assign cho_c = glitch ? (cx_c + ch_c + junk) : (cx_c + ch_c);

    gru_seq_ctrl #(.DATA_WIDTH(8), .FRACT_WIDTH(5), .SEQ_LEN(4), .CNT_W(8), .CELL_LAT(1)) u_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .h_init(h_init),
        .x_data(x_data), .x_valid(x_valid), .x_ready(xr_a), .cell_x(cx_a),
        .cell_h(ch_a), .cell_h_out(cho_a), .h_step(hs_a), .h_step_valid(hsv_a),
        .step_idx(idx_a), .h_final(hf_a), .done(dn_a), .busy(bz_a));

    gru_seq_ctrl #(.DATA_WIDTH(8), .FRACT_WIDTH(5), .SEQ_LEN(4), .CNT_W(8), .CELL_LAT(3)) u_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .h_init(h_init),
        .x_data(x_data), .x_valid(x_valid), .x_ready(xr_b), .cell_x(cx_b),
        .cell_h(ch_b), .cell_h_out(cho_b), .h_step(hs_b), .h_step_valid(hsv_b),
        .step_idx(idx_b), .h_final(hf_b), .done(dn_b), .busy(bz_b));

    gru_seq_ctrl #(.DATA_WIDTH(8), .FRACT_WIDTH(5), .SEQ_LEN(1), .CNT_W(8), .CELL_LAT(1)) u_c (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .h_init(h_init),
        .x_data(x_data), .x_valid(x_valid), .x_ready(xr_c), .cell_x(cx_c),
        .cell_h(ch_c), .cell_h_out(cho_c), .h_step(hs_c), .h_step_valid(hsv_c),
        .step_idx(idx_c), .h_final(hf_c), .done(dn_c), .busy(bz_c));

    logic       o_xr, o_hsv, o_dn, o_bz;
    logic [7:0] o_cx, o_ch, o_hs, o_idx, o_hf;

    // Select the outputs of the instance under test.
    always_comb begin
        case (cur)
            0: begin
                o_xr = xr_a; o_hsv = hsv_a; o_dn = dn_a; o_bz = bz_a; o_cx = cx_a;
                o_ch = ch_a; o_hs = hs_a; o_idx = idx_a; o_hf = hf_a;
            end
            1: begin
                o_xr = xr_b; o_hsv = hsv_b; o_dn = dn_b; o_bz = bz_b; o_cx = cx_b;
                o_ch = ch_b; o_hs = hs_b; o_idx = idx_b; o_hf = hf_b;
            end
            default: begin
                o_xr = xr_c; o_hsv = hsv_c; o_dn = dn_c; o_bz = bz_c; o_cx = cx_c;
                o_ch = ch_c; o_hs = hs_c; o_idx = idx_c; o_hf = hf_c;
            end
        endcase
    end

    // Reference model. A sequence is "running" from an accepted start until
    // done. Each accepted sample schedules a capture CELL_LAT edges later.
    // The last capture schedules the done edge one edge after that.
    int         checks = 0;
    int         errors = 0;
    int         edge_n = 0;
    int         m_lat, m_seq;
    bit         run, wait_x, m_v, m_d;
    int         cap_e, fin_e, k;
    logic [7:0] m_h, m_x, m_hs, m_hf, m_idx;

    task automatic model_reset();
        run = 1'b0; wait_x = 1'b0; m_v = 1'b0; m_d = 1'b0;
        cap_e = -1; fin_e = -1; k = 0;
        m_h = 8'h00; m_x = 8'h00; m_hs = 8'h00; m_hf = 8'h00; m_idx = 8'h00;
    endtask

    task automatic model_update();
        logic [7:0] v;
        m_v = 1'b0;
        m_d = 1'b0;
        if (rst) begin
            model_reset();
        end else if (abort && run) begin
            run = 1'b0; wait_x = 1'b0; cap_e = -1; fin_e = -1; k = 0;
        end else if (!run) begin
            if (start && !abort) begin
                run = 1'b1; wait_x = 1'b1; m_h = h_init; k = 0; cap_e = -1; fin_e = -1;
            end
        end else if (fin_e == edge_n) begin
            run = 1'b0; fin_e = -1; m_d = 1'b1;
        end else if (wait_x) begin
            if (x_valid) begin
                m_x = x_data; wait_x = 1'b0; cap_e = edge_n + m_lat;
            end
        end else if (cap_e == edge_n) begin
            v = m_x + m_h;
            m_h = v; m_hs = v; m_idx = 8'(k); m_v = 1'b1; cap_e = -1;
            if (k == m_seq - 1) begin
                m_hf = v; fin_e = edge_n + 1;
            end else begin
                k = k + 1; wait_x = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h at edge %0d", tag, cur, obs, exp, edge_n);
        end
    endtask

    task automatic check_all();
        chk("x_ready", {31'd0, o_xr}, {31'd0, run && wait_x});
        chk("busy", {31'd0, o_bz}, {31'd0, run});
        chk("cell_x", {24'd0, o_cx}, {24'd0, m_x});
        chk("cell_h", {24'd0, o_ch}, {24'd0, m_h});
        chk("h_step_valid", {31'd0, o_hsv}, {31'd0, m_v});
        chk("h_step", {24'd0, o_hs}, {24'd0, m_hs});
        chk("step_idx", {24'd0, o_idx}, {24'd0, m_idx});
        chk("h_final", {24'd0, o_hf}, {24'd0, m_hf});
        chk("done", {31'd0, o_dn}, {31'd0, m_d});
    endtask

    // Advance one clock. The model steps on the edge, and the outputs are
    // compared on the following falling edge. The next stimulus is applied
    // after that.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_update();
        @(negedge clk);
        check_all();
        glitch = (cap_e >= 0) && (cap_e != edge_n + 1);
        junk   = 8'($urandom_range(1, 255));
    endtask

    task automatic select_dut(input int d);
        cur   = d;
        m_lat = (d == 1) ? 3 : 1;
        m_seq = (d == 2) ? 1 : 4;
        rst = 1'b1; start = 1'b0; abort = 1'b0; x_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic start_seq(input logic [7:0] hi);
        h_init = hi; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic random_phase(input int n);
        repeat (n) begin
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 31) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            x_valid = ($urandom_range(0, 1) == 1);
            x_data  = 8'($urandom);
            h_init  = 8'($urandom);
            tick();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        int  gap;
        bit  aborted, first;
        glitch = 1'b0; junk = 8'h00;
        rst = 1'b1; start = 1'b1; abort = 1'b0; x_valid = 1'b0;
        h_init = 8'h00; x_data = 8'h00;
        cur = 0; m_lat = 1; m_seq = 4;
        model_reset();

        // Reset with start held high; all outputs must come out zero.
        repeat (2) tick();
        rst = 1'b0; start = 1'b0;
        tick();

        // Basic run: h_init=0x10, x=0x01 streamed continuously.
        x_data = 8'h01; x_valid = 1'b1;
        start_seq(8'h10);
        repeat (12) tick();
        chk("final_basic", {24'd0, o_hf}, 32'h14);

        // Five-cycle input gap before step 2.
        gap = 0;
        start_seq(8'h10);
        repeat (30) begin
            if (run && wait_x && k == 2 && gap < 5) begin
                x_valid = 1'b0; gap++;
            end else begin
                x_valid = 1'b1;
            end
            tick();
        end
        chk("final_gap", {24'd0, o_hf}, 32'h14);

        // Abort during SETTLE of step 2, then restart from h_init=0.
        aborted = 1'b0;
        x_valid = 1'b1;
        start_seq(8'h30);
        repeat (12) begin
            abort = (!aborted && run && k == 2 && cap_e >= 0);
            if (abort) aborted = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk("final_after_abort", {24'd0, o_hf}, 32'h14);
        start_seq(8'h00);
        repeat (12) tick();
        chk("final_restart", {24'd0, o_hf}, 32'h04);

        // Reset in WAIT_X with start held, then idle until start; stray
        // starts while busy must be ignored.
        x_valid = 1'b0;
        start_seq(8'h55);
        repeat (3) tick();
        rst = 1'b1; start = 1'b1;
        repeat (2) tick();
        rst = 1'b0; start = 1'b0;
        repeat (3) tick();
        x_valid = 1'b1;
        start_seq(8'h10);
        repeat (14) begin
            start = ($urandom_range(0, 1) == 1) && run;
            tick();
        end
        start = 1'b0;
        repeat (4) tick();
        random_phase(300);

        // CELL_LAT=3: the value sampled on the last settle cycle wins, and
        // 0x7F + 0x01 wraps to 0x80.
        select_dut(1);
        x_data = 8'h7F; x_valid = 1'b1; first = 1'b1;
        start_seq(8'h01);
        repeat (25) begin
            tick();
            if (m_v && first) begin
                chk("first_wrap", {24'd0, o_hs}, 32'h80);
                first = 1'b0;
            end
        end
        random_phase(300);

        // SEQ_LEN=1: a single capture goes straight to done.
        select_dut(2);
        x_data = 8'h03; x_valid = 1'b1;
        start_seq(8'h20);
        repeat (6) tick();
        chk("final_single", {24'd0, o_hf}, 32'h23);
        random_phase(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
